// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command framer: header classes, payload
// length table, FSM state encoding and default sizing.
package spi_cmd_pkg;

  localparam int DEF_FIFO_DEPTH     = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Header class lives in opcode[7:5]
  typedef enum logic [2:0] {
    CLS_NOP     = 3'd0,
    CLS_SET_REG = 3'd1,
    CLS_VERTEX  = 3'd2,
    CLS_DRAW    = 3'd3,
    CLS_CLEAR   = 3'd4,
    CLS_SWAP    = 3'd5,
    CLS_RSVD    = 3'd6,
    CLS_VAR     = 3'd7
  } cmd_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  // Fixed payload byte count per class; CLS_VAR takes its length from the
  // byte after the header and never goes through this table.
  function automatic logic [7:0] fixed_len(input cmd_class_e cls);
    logic [7:0] len;
    case (cls)
      CLS_SET_REG: len = 8'd2;
      CLS_VERTEX:  len = 8'd12;
      CLS_DRAW:    len = 8'd4;
      CLS_CLEAR:   len = 8'd1;
      default:     len = 8'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with count-based full/empty. A push while full is
// accepted when a pop happens in the same cycle, so a full FIFO still
// streams at one byte per cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset, occupancy guards reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_command_framer.sv
// Frames the SPI byte stream into opcode-tagged command beats.
// Optional stall watchdog: define SPI_CMD_TIMEOUT_EN to build it; without it
// cmd_abort is tied low and a partial command waits indefinitely.
module spi_command_framer
  import spi_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] command_wrdata,
  input  logic       command_push,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_opcode,
  output logic [7:0] cmd_data,
  output logic       cmd_first,
  output logic       cmd_last,
  output logic       cmd_abort,
  output logic       ovf_flag,
  input  logic       ovf_clear,
  output logic [7:0] ovf_count
);

  state_e     state, state_n;
  logic [7:0] rem, rem_n;
  logic       first_pend, first_pend_n;
  logic       valid_n, first_n, last_n, abort_n;
  logic [7:0] opcode_n, data_n;
  logic [7:0] head;
  logic       fifo_full, fifo_empty, pop, drop, wd_hit;

  // A byte is consumed only when the output register is free or draining
  assign pop  = !fifo_empty && (!cmd_valid || cmd_ready);
  assign drop = command_push && fifo_full && !pop;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (command_push),
    .wdata (command_wrdata),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
  logic           stalled;

  // Stalled mid-command: nothing buffered and nothing waiting downstream
  assign stalled = (state != ST_IDLE) && fifo_empty && !cmd_valid;
  assign wd_hit  = stalled && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter; any pop (or leaving the stalled condition) restarts it
  always_ff @(posedge clk) begin
    if (rst || !stalled || wd_hit) wd_cnt <= '0;
    else                           wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_hit = 1'b0;
`endif

  // FSM state and output beat register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rem        <= '0;
      first_pend <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_opcode <= '0;
      cmd_data   <= '0;
      cmd_first  <= 1'b0;
      cmd_last   <= 1'b0;
      cmd_abort  <= 1'b0;
    end else begin
      state      <= state_n;
      rem        <= rem_n;
      first_pend <= first_pend_n;
      cmd_valid  <= valid_n;
      cmd_opcode <= opcode_n;
      cmd_data   <= data_n;
      cmd_first  <= first_n;
      cmd_last   <= last_n;
      cmd_abort  <= abort_n;
    end
  end

  // Next state and next beat; fields hold unless a new beat is loaded
  always_comb begin
    state_n      = state;
    rem_n        = rem;
    first_pend_n = first_pend;
    valid_n      = cmd_valid && !cmd_ready;
    opcode_n     = cmd_opcode;
    data_n       = cmd_data;
    first_n      = cmd_first;
    last_n       = cmd_last;
    abort_n      = 1'b0;
    if (pop) begin
      unique case (state)
        ST_IDLE: begin
          opcode_n = head;
          if (cmd_class_e'(head[7:5]) == CLS_VAR) begin
            state_n = ST_LEN;
          end else if (fixed_len(cmd_class_e'(head[7:5])) == 8'd0) begin
            valid_n = 1'b1;
            data_n  = 8'h00;
            first_n = 1'b1;
            last_n  = 1'b1;
          end else begin
            state_n      = ST_PAYLOAD;
            rem_n        = fixed_len(cmd_class_e'(head[7:5]));
            first_pend_n = 1'b1;
          end
        end
        ST_LEN: begin
          if (head == 8'd0) begin
            state_n = ST_IDLE;
            valid_n = 1'b1;
            data_n  = 8'h00;
            first_n = 1'b1;
            last_n  = 1'b1;
          end else begin
            state_n      = ST_PAYLOAD;
            rem_n        = head;
            first_pend_n = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          valid_n      = 1'b1;
          data_n       = head;
          first_n      = first_pend;
          last_n       = (rem == 8'd1);
          first_pend_n = 1'b0;
          rem_n        = rem - 1'b1;
          if (rem == 8'd1) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
    if (wd_hit) begin
      state_n = ST_IDLE;
      abort_n = 1'b1;
    end
  end

  // Overflow flag and saturating drop counter; a drop beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag  <= 1'b0;
      ovf_count <= '0;
    end else if (drop) begin
      ovf_flag  <= 1'b1;
      if (ovf_clear)               ovf_count <= 8'd1;
      else if (ovf_count != 8'hFF) ovf_count <= ovf_count + 1'b1;
    end else if (ovf_clear) begin
      ovf_flag  <= 1'b0;
      ovf_count <= '0;
    end
  end

endmodule

// File: tb/tb_spi_command_framer.sv
// Directed bench for spi_command_framer; beats accepted downstream are
// captured into a queue as {opcode, data, first, last}.
module tb_spi_command_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] command_wrdata;
  logic       command_push;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_opcode, cmd_data;
  logic       cmd_first, cmd_last, cmd_abort;
  logic       ovf_flag, ovf_clear;
  logic [7:0] ovf_count;

  int checks = 0;
  int errors = 0;
  logic [17:0] q[$];
  int abort_seen = 0;
  int abort_with_valid = 0;

  spi_command_framer #(.FIFO_DEPTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .command_wrdata (command_wrdata),
    .command_push   (command_push),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_opcode     (cmd_opcode),
    .cmd_data       (cmd_data),
    .cmd_first      (cmd_first),
    .cmd_last       (cmd_last),
    .cmd_abort      (cmd_abort),
    .ovf_flag       (ovf_flag),
    .ovf_clear      (ovf_clear),
    .ovf_count      (ovf_count)
  );

  always #5 clk = ~clk;

  // Beat and abort monitor
  always @(posedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) q.push_back({cmd_opcode, cmd_data, cmd_first, cmd_last});
      if (cmd_abort) abort_seen++;
      if (cmd_abort && cmd_valid) abort_with_valid++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    command_wrdata = b;
    command_push   = 1'b1;
    tick();
    command_push   = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [17:0] exp);
    if (idx < q.size()) chk(tag, {14'd0, q[idx]}, {14'd0, exp});
    else chk({tag, "_missing"}, q.size(), idx + 1);
  endtask

  task automatic chk_outs_reset(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_opcode"}, cmd_opcode, 0);
    chk({tag, "_data"}, cmd_data, 0);
    chk({tag, "_first"}, cmd_first, 0);
    chk({tag, "_last"}, cmd_last, 0);
    chk({tag, "_abort"}, cmd_abort, 0);
    chk({tag, "_ovf_flag"}, ovf_flag, 0);
    chk({tag, "_ovf_count"}, ovf_count, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; command_wrdata = '0; command_push = 1'b0;
    cmd_ready = 1'b1; ovf_clear = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    chk_outs_reset("reset");

    // NOP: beat registered on the edge after the push edge
    base = q.size();
    push_byte(8'h00);
    tick();
    chk("nop_valid", cmd_valid, 1);
    chk("nop_beat", {cmd_opcode, cmd_data, cmd_first, cmd_last}, {8'h00, 8'h00, 2'b11});
    tick(3);
    chk("nop_count", q.size() - base, 1);

    // SET_REG with two payload bytes
    base = q.size();
    push_byte(8'h20); push_byte(8'h11); push_byte(8'h22);
    tick(6);
    chk("setreg_count", q.size() - base, 2);
    chk_beat("setreg_b0", base,     {8'h20, 8'h11, 2'b10});
    chk_beat("setreg_b1", base + 1, {8'h20, 8'h22, 2'b01});

    // Variable length 3 under backpressure: first beat must hold
    base = q.size();
    cmd_ready = 1'b0;
    push_byte(8'hE0); push_byte(8'h03); push_byte(8'h0A); push_byte(8'h0B); push_byte(8'h0C);
    tick(5);
    chk("var_hold", {cmd_valid, cmd_opcode, cmd_data, cmd_first, cmd_last},
        {1'b1, 8'hE0, 8'h0A, 2'b10});
    cmd_ready = 1'b1;
    tick(6);
    chk("var_count", q.size() - base, 3);
    chk_beat("var_b0", base,     {8'hE0, 8'h0A, 2'b10});
    chk_beat("var_b1", base + 1, {8'hE0, 8'h0B, 2'b00});
    chk_beat("var_b2", base + 2, {8'hE0, 8'h0C, 2'b01});

    // Variable length zero collapses to a single zero beat
    base = q.size();
    push_byte(8'hE0); push_byte(8'h00);
    tick(4);
    chk("var0_count", q.size() - base, 1);
    chk_beat("var0_b0", base, {8'hE0, 8'h00, 2'b11});

    // Overflow: stall a NOP beat, then 20 pushes into a 16-deep FIFO
    base = q.size();
    cmd_ready = 1'b0;
    push_byte(8'h00);
    tick(2);
    chk("ovf_pending", cmd_valid, 1);
    for (int i = 0; i < 20; i++) push_byte(8'h00);
    chk("ovf_flag", ovf_flag, 1);
    chk("ovf_count", ovf_count, 4);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_clr", {ovf_flag, ovf_count}, 9'h000);
    // Clear concurrent with a drop: drop wins
    ovf_clear = 1'b1; push_byte(8'h00); ovf_clear = 1'b0;
    chk("ovf_clr_drop", {ovf_flag, ovf_count}, {1'b1, 8'd1});
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    cmd_ready = 1'b1;
    tick(25);
    chk("ovf_drain", q.size() - base, 17);

`ifdef SPI_CMD_TIMEOUT_EN
    // VERTEX truncated after 5 payload bytes; watchdog aborts
    base = q.size();
    push_byte(8'h40);
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    tick(20);
    chk("wd_beats", q.size() - base, 5);
    chk_beat("wd_b0", base,     {8'h40, 8'h01, 2'b10});
    chk_beat("wd_b4", base + 4, {8'h40, 8'h05, 2'b00});
    chk("wd_abort", abort_seen, 1);
    chk("wd_abort_valid", abort_with_valid, 0);
    base = q.size();
    push_byte(8'h00);
    tick(3);
    chk_beat("wd_nop", base, {8'h00, 8'h00, 2'b11});
`else
    chk("no_abort", abort_seen, 0);
`endif

    // Reset mid-PAYLOAD with bytes still buffered
    cmd_ready = 1'b0;
    push_byte(8'h40); push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    tick(2);
    chk("pre_rst_valid", cmd_valid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_outs_reset("midrst");
    cmd_ready = 1'b1;
    base = q.size();
    tick(5);
    chk("rst_fifo_empty", q.size() - base, 0);
    push_byte(8'hA0);
    tick(3);
    chk("swap_count", q.size() - base, 1);
    chk_beat("swap_b0", base, {8'hA0, 8'h00, 2'b11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
